ps2_scan_receiver: RTL and testbench

PS/2 keyboard front end that turns the raw keyboard clock/data pins into validated scan-code bytes with make/break and extended-key qualification. It sits directly upstream of the scan-code decoder that drives the temperature setpoint register. It synchronises and glitch-filters the pins, frames the 11-bit PS/2 word, and checks start, parity and stop. It absorbs F0/E0 prefixes and emits one qualified key event per completed code.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_line_filter.sv | 44 ++++
 rtl/ps2_scan_receiver.sv | 134 +++++++++++++
 tb/tb_ps2_scan_receiver.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and constants: frame FSM states, prefix bytes,
// frame geometry and the parity rule.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam logic [7:0]  PS2_BREAK      = 8'hF0;
   localparam logic [7:0]  PS2_EXT        = 8'hE0;
   localparam int unsigned PS2_FRAME_BITS = 11;

   // PS/2 uses odd parity across the 8 data bits plus the parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus saturating glitch filter for the PS/2 clock pin,
// with a registered strobe on each filtered falling edge.
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic fall
);

   localparam int unsigned CW = $clog2(FILTER_LEN);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // fall is raised on the same edge the filtered level drops, so it
   // reaches the FSM one cycle later with no extra edge-detect stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
         fall  <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= sync2;
            cnt   <= '0;
            fall  <= level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: frames 11-bit words, checks start/parity/stop,
// absorbs F0/E0 prefixes and emits one qualified key event per scan code.
module ps2_scan_receiver
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       enable_rx,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_break,
   output logic       key_ext,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          fall;
   logic          data_m;
   logic          data_s;
   ps2_state_t    state;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;
   logic          par_bit;
   logic [TW-1:0] tmo_cnt;
   logic          break_pend;
   logic          ext_pend;

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_clk_filter (
      .clk (clk),
      .rst (rst),
      .pin (ps2_clk),
      .fall(fall)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_m <= 1'b1;
         data_s <= 1'b1;
      end else begin
         data_m <= ps2_data;
         data_s <= data_m;
      end
   end

   // tmo_cnt counts cycles since the last consumed fall, so it is loaded
   // with 1 on a fall and expiry fires when it would reach TIMEOUT_CYCLES.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shift      <= '0;
         bit_cnt    <= '0;
         par_bit    <= 1'b0;
         tmo_cnt    <= '0;
         break_pend <= 1'b0;
         ext_pend   <= 1'b0;
         key_valid  <= 1'b0;
         key_code   <= '0;
         key_break  <= 1'b0;
         key_ext    <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;
         if (!enable_rx) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            busy       <= 1'b0;
         end else if (state == IDLE) begin
            if (fall && !data_s) begin
               state   <= DATA;
               bit_cnt <= '0;
               tmo_cnt <= TW'(1);
               busy    <= 1'b1;
            end
         end else if (fall) begin
            tmo_cnt <= TW'(1);
            case (state)
               DATA: begin
                  shift   <= {data_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par_bit <= data_s;
                  state   <= STOP;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (odd_parity_ok(shift, par_bit) && data_s) begin
                     if (shift == PS2_BREAK) begin
                        break_pend <= 1'b1;
                     end else if (shift == PS2_EXT) begin
                        ext_pend <= 1'b1;
                     end else begin
                        key_code   <= shift;
                        key_break  <= break_pend;
                        key_ext    <= ext_pend;
                        key_valid  <= 1'b1;
                        break_pend <= 1'b0;
                        ext_pend   <= 1'b0;
                     end
                  end else begin
                     frame_err  <= 1'b1;
                     break_pend <= 1'b0;
                     ext_pend   <= 1'b0;
                  end
               end
            endcase
         end else if (tmo_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_err  <= 1'b1;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver: directed vector table, multi-cycle
// corner sequences and randomized frames against a key-event reference model.
module tb_ps2_scan_receiver;
   import ps2_pkg::*;

   localparam int unsigned FL   = 8;
   localparam int unsigned TMO  = 400;
   localparam int unsigned HALF = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       enable_rx = 1'b1;
   logic       key_valid, key_break, key_ext, frame_err, busy;
   logic [7:0] key_code;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_fall_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_scan_receiver #(
      .FILTER_LEN    (FL),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .enable_rx(enable_rx),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_break(key_break),
      .key_ext  (key_ext),
      .frame_err(frame_err),
      .busy     (busy)
   );

   typedef struct {
      bit         is_err;
      logic [7:0] code;
      logic       brk;
      logic       ext;
      logic       bsy;
      int         at;
   } ev_t;

   typedef struct {
      logic [7:0] d;
      bit         bp;
      bit         bs;
      bit         has;
      bit         err;
      logic [7:0] code;
      bit         brk;
      bit         ext;
   } vec_t;

   ev_t  ev_q[$];
   vec_t tbl[11];
   bit   m_brk = 1'b0;
   bit   m_ext = 1'b0;

   // Every strobe cycle becomes one event; overlapping or stretched strobes show up as extra events.
   always @(negedge clk) begin
      if (rst && key_valid) ev_q.push_back('{1'b0, key_code, key_break, key_ext, busy, cyc});
      if (rst && frame_err) ev_q.push_back('{1'b1, key_code, key_break, key_ext, busy, cyc});
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic b, input bit glitch);
      @(negedge clk);
      ps2_data = b;
      if (glitch) begin
         repeat (5) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (3) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (HALF - 8) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_word(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_at, input int dis_at);
      logic [PS2_FRAME_BITS-1:0] w;
      w = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         if (i == dis_at) enable_rx = 1'b0;
         send_bit(w[i], i == glitch_at);
         if (i == dis_at) begin
            vectors++;
            if (busy !== 1'b0) begin
               miscompares++;
               $display("FAIL busy_after_disable: got %b, expected 0", busy);
            end
         end
      end
      ps2_data = 1'b1;
   endtask

   // Reference model at key-event level: prefixes accumulate, errors clear them.
   task automatic model_frame(input logic [7:0] d, input bit ok, output bit has, output ev_t e);
      has = 1'b0;
      e = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0};
      if (!ok) begin
         has = 1'b1;
         e.is_err = 1'b1;
         m_brk = 1'b0;
         m_ext = 1'b0;
      end else if (d == 8'hF0) begin
         m_brk = 1'b1;
      end else if (d == 8'hE0) begin
         m_ext = 1'b1;
      end else begin
         has = 1'b1;
         e.code = d;
         e.brk = m_brk;
         e.ext = m_ext;
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   task automatic check_ev(input string name, input bit has, input ev_t e, input bit chk_lat);
      ev_t g;
      repeat (FL + 8) @(negedge clk);
      vectors++;
      if (ev_q.size() != int'(has)) begin
         miscompares++;
         $display("FAIL %s: strobe count %0d, expected %0d", name, ev_q.size(), has);
      end else if (has) begin
         g = ev_q[0];
         vectors++;
         if (g.is_err !== e.is_err || g.bsy !== 1'b0 ||
             (!e.is_err && (g.code !== e.code || g.brk !== e.brk || g.ext !== e.ext))) begin
            miscompares++;
            $display("FAIL %s: got err=%b code=%h brk=%b ext=%b busy=%b, expected err=%b code=%h brk=%b ext=%b busy=0",
                     name, g.is_err, g.code, g.brk, g.ext, g.bsy, e.is_err, e.code, e.brk, e.ext);
         end
         if (chk_lat) begin
            vectors++;
            if (g.at != last_fall_cyc + int'(FL) + 3) begin
               miscompares++;
               $display("FAIL %s_latency: got %0d cycles, expected %0d", name, g.at - last_fall_cyc, FL + 3);
            end
         end
      end
      ev_q.delete();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic check_reset(input string name);
      vectors++;
      if ({key_valid, key_code, key_break, key_ext, frame_err, busy} !== 13'h0) begin
         miscompares++;
         $display("FAIL %s: got kv=%b code=%h brk=%b ext=%b ferr=%b busy=%b, expected all zero",
                  name, key_valid, key_code, key_break, key_ext, frame_err, busy);
      end
   endtask

   function automatic ev_t key_ev(input logic [7:0] c, input bit b, input bit x);
      return '{1'b0, c, b, x, 1'b0, 0};
   endfunction

   initial begin
      ev_t  e;
      bit   has;
      bit   found;
      logic [7:0] d;
      bit   bp, bs;

      tbl[0]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0};
      tbl[1]  = '{8'hF0, 0, 0, 0, 0, 8'h00, 0, 0};
      tbl[2]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 1, 0};
      tbl[3]  = '{8'hE0, 0, 0, 0, 0, 8'h00, 0, 0};
      tbl[4]  = '{8'hF0, 0, 0, 0, 0, 8'h00, 0, 0};
      tbl[5]  = '{8'h75, 0, 0, 1, 0, 8'h75, 1, 1};
      tbl[6]  = '{8'h1C, 1, 0, 1, 1, 8'h00, 0, 0};
      tbl[7]  = '{8'h16, 0, 0, 1, 0, 8'h16, 0, 0};
      tbl[8]  = '{8'hF0, 0, 0, 0, 0, 8'h00, 0, 0};
      tbl[9]  = '{8'h16, 0, 1, 1, 1, 8'h00, 0, 0};
      tbl[10] = '{8'h16, 0, 0, 1, 0, 8'h16, 0, 0};

      repeat (5) @(negedge clk);
      check_reset("reset_values");
      rst = 1'b1;
      repeat (40) @(negedge clk);

      foreach (tbl[i]) begin
         send_word(tbl[i].d, tbl[i].bp, tbl[i].bs, PS2_FRAME_BITS, -1, -1);
         e = tbl[i].err ? '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0} : key_ev(tbl[i].code, tbl[i].brk, tbl[i].ext);
         check_ev($sformatf("table%0d", i), tbl[i].has, e, 1'b1);
      end

      // Partial frame then idle lines: timeout must abort exactly on schedule.
      send_word(8'h45, 0, 0, 5, -1, -1);
      found = 1'b0;
      for (int k = 0; k < int'(TMO) + 200 && !found; k++) begin
         @(negedge clk);
         if (ev_q.size() > 0) found = 1'b1;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL timeout: got no frame_err within %0d cycles, expected one", TMO + 200);
      end else begin
         if (!ev_q[0].is_err || ev_q[0].bsy !== 1'b0 ||
             ev_q[0].at != last_fall_cyc + int'(FL) + 2 + int'(TMO)) begin
            miscompares++;
            $display("FAIL timeout: got err=%b busy=%b at %0d, expected err=1 busy=0 at %0d",
                     ev_q[0].is_err, ev_q[0].bsy, ev_q[0].at - last_fall_cyc, FL + 2 + TMO);
         end
      end
      ev_q.delete();
      repeat (HALF) @(negedge clk);
      send_word(8'h45, 0, 0, PS2_FRAME_BITS, -1, -1);
      check_ev("after_timeout", 1'b1, key_ev(8'h45, 0, 0), 1'b1);

      // Short clock glitches (data low) must not be seen as edges.
      ps2_data = 1'b0;
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (30) @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_idle_busy: got %b, expected 0", busy);
      end
      check_ev("glitch_idle", 1'b0, e, 1'b0);
      send_word(8'h29, 0, 0, PS2_FRAME_BITS, 3, -1);
      check_ev("glitch_mid", 1'b1, key_ev(8'h29, 0, 0), 1'b1);

      // enable_rx dropped mid-frame clears the pending break prefix.
      send_word(8'hF0, 0, 0, PS2_FRAME_BITS, -1, -1);
      check_ev("pre_disable_f0", 1'b0, e, 1'b0);
      send_word(8'h1C, 0, 0, PS2_FRAME_BITS, -1, 4);
      check_ev("disabled", 1'b0, e, 1'b0);
      enable_rx = 1'b1;
      repeat (HALF) @(negedge clk);
      send_word(8'h1C, 0, 0, PS2_FRAME_BITS, -1, -1);
      check_ev("after_enable", 1'b1, key_ev(8'h1C, 0, 0), 1'b1);

      // Asynchronous reset mid-frame.
      send_word(8'h33, 0, 0, PS2_FRAME_BITS, -1, -1);
      check_ev("pre_reset", 1'b1, key_ev(8'h33, 0, 0), 1'b0);
      send_word(8'hF0, 0, 0, PS2_FRAME_BITS, -1, -1);
      check_ev("pre_reset_f0", 1'b0, e, 1'b0);
      send_word(8'h1C, 0, 0, 6, -1, -1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset("reset_mid_frame");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      send_word(8'h1C, 0, 0, PS2_FRAME_BITS, -1, -1);
      check_ev("after_reset", 1'b1, key_ev(8'h1C, 0, 0), 1'b1);

      // Randomized frames against the event-level model.
      m_brk = 1'b0;
      m_ext = 1'b0;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(7))
            0: d = 8'hF0;
            1: d = 8'hE0;
            default: d = 8'($urandom);
         endcase
         bp = ($urandom_range(9) == 0);
         bs = ($urandom_range(19) == 0);
         send_word(d, bp, bs, PS2_FRAME_BITS, -1, -1);
         model_frame(d, !bp && !bs, has, e);
         check_ev($sformatf("rand%0d_%h", n, d), has, e, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
